// File: rtl/snake_pkg.sv
// Shared constants, FSM encoding and helpers for the snake score overlay.
package snake_pkg;

    localparam int SCORE_W    = 14;
    localparam int DIGITS     = 4;
    localparam int GLYPH_W    = 16;
    localparam int GLYPH_H    = 32;
    localparam int GLYPH_SIZE = GLYPH_W * GLYPH_H;   // address stride between glyphs
    localparam int BCD_W      = 4 * DIGITS;
    localparam int CNT_W      = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W-1:0] MAX_SCORE   = SCORE_W'(10**DIGITS - 1);
    localparam logic [7:0]         TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    function automatic logic [SCORE_W-1:0] saturate_score(input logic [SCORE_W-1:0] v);
        return (v > MAX_SCORE) ? MAX_SCORE : v;
    endfunction

endpackage

// File: rtl/score_digit_renderer_bcd.sv
// Iterative double-dabble binary-to-BCD converter; one shift per cycle.
//  state     | meaning
//  ST_IDLE   | waiting for start, captures (saturated) value
//  ST_LOAD   | clear BCD accumulator, arm shift counter
//  ST_SHIFT  | add-3 adjust then shift one bit per cycle
//  ST_COMMIT | BCD result stable, done pulse for one cycle
module bcd_converter
    import snake_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd
);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_adj;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (r_cnt == CNT_W'(1)) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE);
        o_done = (r_state == ST_COMMIT);
        o_bcd  = r_bcd;
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) r_bin <= saturate_score(i_value);
                end
                ST_LOAD: begin
                    r_bcd <= '0;
                    r_cnt <= CNT_W'(SCORE_W);
                end
                ST_SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
                    r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score overlay: BCD display registers plus a 3-stage pixel -> sprite RAM -> colour pipeline.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits (units digit always shown).
module score_digit_renderer
    import snake_pkg::*;
#(
    parameter int ORIGIN_X   = 16,
    parameter int ORIGIN_Y   = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score_i,
    input  logic                  score_load,
    output logic                  busy_o,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  pix_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] pix_o,
    output logic                  pix_hit_o
);

    localparam int         LOG_W = $clog2(GLYPH_W);
    localparam int         LOG_H = $clog2(GLYPH_H);
    localparam int         IDX_W = $clog2(DIGITS);
    localparam logic [9:0] X0    = 10'(ORIGIN_X);
    localparam logic [9:0] Y0    = 10'(ORIGIN_Y);
    localparam logic [9:0] WIN_W = 10'(DIGITS * GLYPH_W);
    localparam logic [9:0] WIN_H = 10'(GLYPH_H);

    logic               w_conv_busy;
    logic               w_conv_done;
    logic [BCD_W-1:0]   w_bcd;
    logic               w_start;
    logic [SCORE_W-1:0] w_start_val;
    logic               r_pend_vld;
    logic [SCORE_W-1:0] r_pend_val;
    logic [3:0]         r_disp [DIGITS];

    logic [9:0]            w_dx;
    logic [9:0]            w_dy;
    logic                  w_in_win;
    logic [IDX_W-1:0]      w_idx;
    logic [LOG_W-1:0]      w_col;
    logic [LOG_H-1:0]      w_row;
    logic [3:0]            w_glyph;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_blank;
    logic                  w_issue;
    logic                  r_v2;
    logic                  w_opaque;

    // A load that arrives mid-conversion waits here; a newer one overwrites it.
    assign w_start     = (score_load || r_pend_vld) && !w_conv_busy;
    assign w_start_val = score_load ? score_i : r_pend_val;
    assign busy_o      = w_conv_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
        end else if (score_load && w_conv_busy) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= score_i;
        end else if (w_start) begin
            r_pend_vld <= 1'b0;
        end
    end

    bcd_converter u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_value (w_start_val),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) r_disp[i] <= 4'd0;
        end else if (w_conv_done) begin
            for (int i = 0; i < DIGITS; i++) r_disp[i] <= w_bcd[4*(DIGITS-1-i) +: 4];
        end
    end

    assign w_dx     = pix_x - X0;
    assign w_dy     = pix_y - Y0;
    assign w_in_win = pix_en && (pix_x >= X0) && (w_dx < WIN_W) && (pix_y >= Y0) && (w_dy < WIN_H);
    assign w_idx    = w_dx[LOG_W +: IDX_W];
    assign w_col    = w_dx[LOG_W-1:0];
    assign w_row    = w_dy[LOG_H-1:0];
    assign w_glyph  = r_disp[w_idx];
    assign w_addr   = ADDR_WIDTH'(w_glyph) * ADDR_WIDTH'(GLYPH_SIZE)
                    + ADDR_WIDTH'(w_row) * ADDR_WIDTH'(GLYPH_W)
                    + ADDR_WIDTH'(w_col);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_lz;

    always_comb begin
        logic run;
        run  = 1'b1;
        w_lz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            run     = run && (r_disp[i] == 4'd0);
            w_lz[i] = run;
        end
    end

    assign w_blank = w_lz[w_idx] && (w_idx != IDX_W'(DIGITS - 1));
`else
    assign w_blank = 1'b0;
`endif

    assign w_issue = w_in_win && !w_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
            r_v2     <= 1'b0;
        end else begin
            rom_addr <= w_issue ? w_addr : '0;
            rom_en   <= w_issue;
            r_v2     <= rom_en;
        end
    end

    assign w_opaque = r_v2 && (rom_data != DATA_WIDTH'(TRANSPARENT));

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_o     <= '0;
            pix_hit_o <= 1'b0;
        end else begin
            pix_o     <= w_opaque ? rom_data : DATA_WIDTH'(TRANSPARENT);
            pix_hit_o <= w_opaque;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer with a behavioural sprite RAM.
module tb_score_digit_renderer;

    localparam int X0 = 16;
    localparam int Y0 = 16;
    localparam int MEM_N = 10 * 32 * 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] score_i;
    logic        score_load;
    logic        busy_o;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_en;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic [7:0]  pix_o;
    logic        pix_hit_o;

    logic [7:0] mem [0:MEM_N-1];
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int   x;
        int   y;
        logic en;
        logic exp_en;
        int   exp_addr;
    } pix_vec_t;

    pix_vec_t vecs [10];

    always #5 clk = ~clk;

    score_digit_renderer #(
        .ORIGIN_X   (X0),
        .ORIGIN_Y   (Y0),
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .score_i    (score_i),
        .score_load (score_load),
        .busy_o     (busy_o),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_en     (pix_en),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .pix_o      (pix_o),
        .pix_hit_o  (pix_hit_o)
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= (int'(rom_addr) < MEM_N) ? mem[rom_addr] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_score(input int val);
        score_i    = 14'(val);
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick();
        end
        chk("busy_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic check_digits(input int d0, input int d1, input int d2, input int d3, input string tag);
        int   d [4];
        logic lead;
        logic exp_en;
        d    = '{d0, d1, d2, d3};
        lead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lead   = lead && (d[i] == 0);
            exp_en = 1'b1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            if (lead && i < 3) exp_en = 1'b0;
`endif
            pix_x  = 10'(X0 + i * 16 + 3);
            pix_y  = 10'(Y0 + 7);
            pix_en = 1'b1;
            tick();
            chk($sformatf("%s_en%0d", tag, i), 32'(rom_en), 32'(exp_en));
            if (exp_en) chk($sformatf("%s_addr%0d", tag, i), 32'(rom_addr), 32'((d[i] * 32 + 7) * 16 + 3));
        end
        pix_en = 1'b0;
    endtask

    initial begin
        int n;
        int px [5];
        int py [5];
        int pa [5];
        logic [7:0] ev;

        for (int a = 0; a < MEM_N; a++) mem[a] = 8'(a * 37 + 11);
        mem[565] = 8'h3C;
        mem[566] = 8'h00;

        reset = 1'b1; score_i = '0; score_load = 1'b0;
        pix_x = '0; pix_y = '0; pix_en = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pix_o", 32'(pix_o), 32'd0);
        chk("rst_pix_hit", 32'(pix_hit_o), 32'd0);
        reset = 1'b0;
        tick();
        check_digits(0, 0, 0, 0, "rst_disp");

        load_score(1234);
        wait_idle(n);
        chk("busy_cycles_1234", 32'(n), 32'd16);
        check_digits(1, 2, 3, 4, "disp1234");

        // x, y, pix_en, expected rom_en, expected rom_addr (display 1234)
        vecs[0] = '{32,   16,   1'b1, 1'b1, 1024};
        vecs[1] = '{16,   16,   1'b1, 1'b1, 512};
        vecs[2] = '{79,   47,   1'b1, 1'b1, 2559};
        vecs[3] = '{53,   30,   1'b1, 1'b1, 1765};
        vecs[4] = '{80,   16,   1'b1, 1'b0, 0};
        vecs[5] = '{16,   48,   1'b1, 1'b0, 0};
        vecs[6] = '{15,   20,   1'b1, 1'b0, 0};
        vecs[7] = '{20,   15,   1'b1, 1'b0, 0};
        vecs[8] = '{40,   20,   1'b0, 1'b0, 0};
        vecs[9] = '{1023, 1023, 1'b1, 1'b0, 0};
        for (int v = 0; v < 10; v++) begin
            pix_x  = 10'(vecs[v].x);
            pix_y  = 10'(vecs[v].y);
            pix_en = vecs[v].en;
            tick();
            chk($sformatf("vec%0d_en", v), 32'(rom_en), 32'(vecs[v].exp_en));
            if (vecs[v].exp_en) chk($sformatf("vec%0d_addr", v), 32'(rom_addr), 32'(vecs[v].exp_addr));
        end
        pix_en = 1'b0;
        repeat (4) tick();

        // back-to-back pixels through the full 3-cycle pipe
        px = '{X0 + 5, X0 + 6, X0 + 21, X0 + 80, X0 + 49};
        py = '{Y0 + 3, Y0 + 3, Y0 + 3,  Y0,      Y0 + 31};
        pa = '{565,    566,    1077,    -1,      2545};
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                pix_x  = 10'(px[c]);
                pix_y  = 10'(py[c]);
                pix_en = 1'b1;
            end else begin
                pix_en = 1'b0;
            end
            tick();
            if (c == 1) chk("pipe_not_early", 32'(pix_hit_o), 32'd0);
            if (c >= 2) begin
                ev = (pa[c-2] < 0) ? 8'h00 : mem[pa[c-2]];
                chk($sformatf("pipe%0d_pix", c - 2), 32'(pix_o), 32'(ev));
                chk($sformatf("pipe%0d_hit", c - 2), 32'(pix_hit_o), 32'(ev != 8'h00));
            end
        end
        pix_en = 1'b0;

        load_score(16383);
        wait_idle(n);
        check_digits(9, 9, 9, 9, "sat16383");
        load_score(10000);
        wait_idle(n);
        check_digits(9, 9, 9, 9, "sat10000");
        load_score(0);
        wait_idle(n);
        check_digits(0, 0, 0, 0, "zero");

        load_score(77);
        tick();
        load_score(500);
        wait_idle(n);
        tick();
        chk("pending_start", 32'(busy_o), 32'd1);
        check_digits(0, 0, 7, 7, "mid77");
        wait_idle(n);
        check_digits(0, 5, 0, 0, "final500");

        load_score(42);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("abort_stays_idle", 32'(busy_o), 32'd0);
        check_digits(0, 0, 0, 0, "abort_disp");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_digit_renderer.md
# score_digit_renderer

Renders the numeric score overlay for the snake display. Converts a binary score to BCD with an iterative double-dabble FSM, maps the current VGA pixel coordinate to a digit glyph, and drives address/enable into the 8-bit number-sprite block RAM. Consumes the RAM's registered read data and emits a pixel-aligned colour plus hit flag to the downstream colour mux.

## Interface
- SCORE_W, 14: width of binary score input
- DIGITS, 4: decimal digits displayed, most significant leftmost
- GLYPH_W, 16: glyph width in pixels, power of two
- GLYPH_H, 32: glyph height in pixels, power of two
- ORIGIN_X, 16: left pixel column of the score window
- ORIGIN_Y, 16: top pixel row of the score window
- ADDR_WIDTH, 16: sprite RAM address width
- DATA_WIDTH, 8: sprite RAM data width
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- score_i  in  SCORE_W  binary score, sampled on score_load
- score_load  in  1  one-cycle pulse requesting a display update
- busy_o  out  1  BCD conversion in progress
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- pix_en  in  1  pixel coordinate valid this cycle
- rom_addr  out  ADDR_WIDTH  sprite RAM address (registered)
- rom_en  out  1  sprite RAM enable (registered)
- rom_data  in  DATA_WIDTH  sprite RAM read data, valid one cycle after rom_addr
- pix_o  out  DATA_WIDTH  overlay colour (registered)
- pix_hit_o  out  1  overlay pixel opaque this cycle (registered)

## Operation
- Sprite layout: glyphs 0–9 stacked; address = (glyph*GLYPH_H + row)*GLYPH_W + col. Parent ties RAM we=0, data_i=0.
- Conversion FSM states: IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE.
- IDLE: on score_load, capture score_i, go LOAD. Score > 10^DIGITS−1 saturates to all nines.
- LOAD: clear BCD shift register, counter = SCORE_W.
- SHIFT: per cycle, add 3 to each nibble ≥ 5, then shift left one bit, decrement counter; on zero go COMMIT.
- COMMIT: copy BCD nibbles into display registers atomically (no partial frame update), go IDLE.
- busy_o high in LOAD, SHIFT and COMMIT.
- score_load while busy: latch into a single pending register (last value wins); start it from IDLE on the next cycle.
- Pixel window: x in [ORIGIN_X, ORIGIN_X+DIGITS*GLYPH_W), y in [ORIGIN_Y, ORIGIN_Y+GLYPH_H). Digit index = (x−ORIGIN_X)>>log2(GLYPH_W); col/row are the low bits. Unsigned comparisons only.
- Colour 0x00 is transparent: pix_hit_o=0, pix_o=0.
- Outside window or pix_en=0: rom_en=0, pix_hit_o=0, pix_o=0.

## Timing
- Pixel path latency 3 cycles: pix_x/pix_y at edge t -> rom_addr/rom_en at t+1 -> rom_data at t+2 -> pix_o/pix_hit_o at t+3. Fully pipelined, one pixel per cycle.
- Conversion latency: score_load at t -> display updated at t+SCORE_W+2; busy_o deasserts the same cycle.
- Reset: all display digits 0, pending cleared, FSM IDLE, busy_o=0, rom_addr=0, rom_en=0, pix_o=0, pix_hit_o=0. Reset mid-conversion aborts it; display stays 0.
- Display register changes affect pixels entering stage 0 after COMMIT; in-flight pixels keep their issued glyph.

## Configuration
- SCORE_LEADING_ZERO_BLANK_EN defined: leading zero digits (all except the units digit) render transparent with rom_en=0; score 0 shows a single "0".
- Undefined: all DIGITS digits always render, zero-padded.

## Structure
- Package snake_pkg: SCORE_W, DIGITS, GLYPH_W, GLYPH_H, glyph base-address constant, FSM state encoding, TRANSPARENT=8'h00.
- Sub-module bcd_converter: the double-dabble FSM with start/busy/done and BCD output; the top holds the pixel pipeline and display registers.

## Test plan
- Reset then score_load with score_i=1234 -> busy_o high 16 cycles, display digits 1,2,3,4; pixel (ORIGIN_X+16, ORIGIN_Y) issues rom_addr=(2*32+0)*16+0=1024.
- score_i=16383 -> saturated display 9999.
- Pixel at (ORIGIN_X+5, ORIGIN_Y+3), rom_data=0x3C -> pix_o=0x3C, pix_hit_o=1 exactly 3 cycles later; rom_data=0x00 -> pix_hit_o=0.
- Loads 77 then 500 two cycles apart -> display ends at 0500 (or 500 blanked with _EN); no intermediate tearing.
- Pixel at (ORIGIN_X+64, ORIGIN_Y) and (ORIGIN_X, ORIGIN_Y+32) -> rom_en=0, pix_hit_o=0.
- Reset asserted mid-conversion of 42 -> busy_o=0 next cycle, display 0000.
